// File: rtl/shift_reg_pkg.sv
// Shared types and sizing helpers for the shift-register family (PISO now, SIPO later).
package shift_reg_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } piso_state_t;

    // Bits needed to index a WIDTH-bit word, never less than one.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bit_counter.sv
// Bit-position counter for serialisers: synchronous clear wins over increment.
module bit_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shifter: one word per valid/ready load, one bit per clock.
// A load accepted in the last-bit cycle starts the next word with no idle gap.
module piso_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             last_bit,
    output logic             frame_done,
    output logic             busy
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    piso_state_t      state_q;
    piso_state_t      state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             frame_done_q;
    logic [CW-1:0]    cnt;
    logic             cnt_at_last;
    logic             load_fire;
    logic             cnt_clr;
    logic             cnt_inc;

    bit_counter #(
        .WIDTH (CW)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .cnt_o (cnt)
    );

    assign cnt_at_last = (cnt == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        load_ready = 1'b0;
        last_bit   = 1'b0;
        busy       = 1'b0;
        load_fire  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                load_ready = 1'b1;
            end
            ST_SHIFT: begin
                busy       = 1'b1;
                last_bit   = cnt_at_last;
                load_ready = cnt_at_last;
            end
            default: begin
                load_ready = 1'b0;
            end
        endcase

        load_fire = load_valid & load_ready;

        // A load in the last-bit cycle takes priority over the return to IDLE.
        if (load_fire) begin
            shreg_d = load_data;
            cnt_clr = 1'b1;
            state_d = ST_SHIFT;
        end else if (state_q == ST_SHIFT) begin
            cnt_inc = 1'b1;
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
            if (cnt_at_last) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            frame_done_q <= last_bit;
        end
    end

    assign dout_valid = busy;
    assign dout       = busy & (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_piso_shift_reg.sv
// Drives an MSB-first and an LSB-first instance with identical loads and scores both.
module tb_piso_shift_reg;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         load_valid;
    logic [W-1:0] load_data;

    logic rdy_a, dout_a, dv_a, lb_a, fd_a, busy_a;
    logic rdy_b, dout_b, dv_b, lb_b, fd_b, busy_b;

    int n_checks = 0;
    int n_fail   = 0;
    int n_sent   = 0;
    int n_acc    = 0;

    // Reference model state
    bit   m_shift = 1'b0;
    int   m_cnt   = 0;
    bit   m_fd    = 1'b0;
    bit   chk_en  = 1'b0;
    bit   qm[$];
    bit   ql[$];
    logic m_ready;
    logic m_last;

    assign m_ready = !m_shift || (m_cnt == W - 1);
    assign m_last  = m_shift && (m_cnt == W - 1);

    piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (rdy_a),
        .dout       (dout_a),
        .dout_valid (dv_a),
        .last_bit   (lb_a),
        .frame_done (fd_a),
        .busy       (busy_a)
    );

    piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (rdy_b),
        .dout       (dout_b),
        .dout_valid (dv_b),
        .last_bit   (lb_b),
        .frame_done (fd_b),
        .busy       (busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // Model update: scoreboard bits are pushed in shift order when a load is accepted.
    initial begin
        bit rdy;
        bit lst;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_shift = 1'b0;
                m_cnt   = 0;
                m_fd    = 1'b0;
                qm.delete();
                ql.delete();
                chk_en  = 1'b1;
            end else begin
                rdy  = !m_shift || (m_cnt == W - 1);
                lst  = m_shift && (m_cnt == W - 1);
                m_fd = lst;
                if (m_shift) begin
                    if (qm.size() > 0) void'(qm.pop_front());
                    if (ql.size() > 0) void'(ql.pop_front());
                end
                if (load_valid && rdy) begin
                    for (int i = 0; i < W; i++) begin
                        qm.push_back(load_data[W-1-i]);
                        ql.push_back(load_data[i]);
                    end
                    m_shift = 1'b1;
                    m_cnt   = 0;
                    n_acc++;
                end else if (m_shift) begin
                    if (m_cnt == W - 1) m_shift = 1'b0;
                    m_cnt++;
                end
            end
        end
    end

    // Output checks, away from the active edge.
    initial begin
        bit exp_a;
        bit exp_b;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (m_shift && (qm.size() == 0 || ql.size() == 0)) begin
                    chk("sb_empty", 32'(1), 32'(0));
                end
                exp_a = (m_shift && qm.size() > 0) ? qm[0] : 1'b0;
                exp_b = (m_shift && ql.size() > 0) ? ql[0] : 1'b0;
                chk("msb_dout",       32'(dout_a), 32'(exp_a));
                chk("msb_dout_valid", 32'(dv_a),   32'(m_shift));
                chk("msb_busy",       32'(busy_a), 32'(m_shift));
                chk("msb_last_bit",   32'(lb_a),   32'(m_last));
                chk("msb_frame_done", 32'(fd_a),   32'(m_fd));
                chk("msb_load_ready", 32'(rdy_a),  32'(m_ready));
                chk("lsb_dout",       32'(dout_b), 32'(exp_b));
                chk("lsb_dout_valid", 32'(dv_b),   32'(m_shift));
                chk("lsb_busy",       32'(busy_b), 32'(m_shift));
                chk("lsb_last_bit",   32'(lb_b),   32'(m_last));
                chk("lsb_frame_done", 32'(fd_b),   32'(m_fd));
                chk("lsb_load_ready", 32'(rdy_b),  32'(m_ready));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents a word and holds it until the edge on which it is taken; leaves load_valid high.
    task automatic send(input logic [W-1:0] w);
        int c;
        c          = 0;
        load_valid = 1'b1;
        load_data  = w;
        n_sent++;
        @(negedge clk);
        while (!m_ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (!m_ready) chk("send_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rw;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Single word
        send(4'b1011);
        load_valid = 1'b0;
        idle(7);

        // Back-to-back, valid held
        send(4'b1011);
        send(4'b0110);
        load_valid = 1'b0;
        idle(7);

        // Load presented during bit 2 is held off until the last-bit cycle
        send(4'b1011);
        load_valid = 1'b0;
        idle(2);
        send(4'b0000);
        load_valid = 1'b0;
        idle(7);

        // Reset during bit 2 aborts the word
        send(4'b1011);
        load_valid = 1'b0;
        idle(2);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        send(4'b0101);
        load_valid = 1'b0;
        idle(7);

        // Random words with random gaps
        for (int k = 0; k < 30; k++) begin
            rw = W'($urandom);
            send(rw);
            if ($urandom_range(0, 1) == 1) begin
                load_valid = 1'b0;
                idle($urandom_range(0, 5));
            end
        end
        load_valid = 1'b0;
        idle(8);

        chk("words_accepted", 32'(n_acc), 32'(n_sent));
        chk("sb_drained", 32'(qm.size() + ql.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_shift_reg.md
# piso_shift_reg

Parallel-in serial-out shift register. It is the transmit-side counterpart of the 4-bit SIPO shift register: it accepts a WIDTH-bit word through a valid/ready load handshake and emits it one bit per clock on `dout`. A bit counter and a two-state FSM frame each word. Back-to-back loads stream with no idle gap, so the output can feed a SIPO directly.

## Interface
- `WIDTH`, default 4: word width in bits, must be at least 2.
- `MSB_FIRST`, default 1: 1 shifts out bit WIDTH-1 first; 0 shifts out bit 0 first.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `load_valid`  in  1  `load_data` is presented for transfer.
- `load_data`  in  WIDTH  parallel word to serialise.
- `load_ready`  out  1  the block accepts a word on this edge if `load_valid` is high.
- `dout`  out  1  serial data bit.
- `dout_valid`  out  1  `dout` carries a data bit this cycle.
- `last_bit`  out  1  `dout` is the final bit of the current word.
- `frame_done`  out  1  registered one-cycle pulse after a word's last bit.
- `busy`  out  1  FSM is in SHIFT.

## Operation
- **State:** FSM states IDLE and SHIFT. Storage is `shreg[WIDTH-1:0]` plus `cnt`, with width clog2(WIDTH).
- **Reset:** on `rst_n`=0 at a clock edge:
  - state goes to IDLE, `shreg` to 0, `cnt` to 0, `frame_done` to 0.
  - Outputs then read `dout`=0, `dout_valid`=0, `last_bit`=0, `busy`=0, `load_ready`=1.
  - Reset overrides any load or shift in the same cycle and aborts a word in progress. No `frame_done` is produced for an aborted word.
- **Handshake:** `load_ready` = (state==IDLE) | (state==SHIFT & cnt==WIDTH-1). The handshake completes on an edge where `load_valid` & `load_ready` are both high. On that edge:
  - `shreg` <= `load_data`, `cnt` <= 0, state <= SHIFT.
- **Held data:** `load_valid` asserted while `load_ready`=0 is ignored. `load_data` is not sampled and `shreg` is unaffected. The upstream holds the word until a later edge with `load_ready`=1.
- **In SHIFT without a handshake:** on each edge `cnt` increments.
  - MSB_FIRST=1: `shreg` shifts left, zero-filling the LSB.
  - MSB_FIRST=0: `shreg` shifts right, zero-filling the MSB.
  - When `cnt`==WIDTH-1, state returns to IDLE.
- **Combinational outputs:**
  - `dout` = `shreg[WIDTH-1]` when MSB_FIRST=1, else `shreg[0]`. It is forced to 0 in IDLE.
  - `dout_valid` = `busy` = (state==SHIFT).
  - `last_bit` = SHIFT & cnt==WIDTH-1.
- **frame_done:** a register that captures `last_bit` on every edge, so it pulses for exactly one cycle after each word. This includes back-to-back words, where it is asserted in the first bit cycle of the following word.
- **Simultaneous load and last bit:** the load wins. The new word's first bit follows the old word's last bit with no gap, and state stays SHIFT.

## Timing
- **Latency:** word accepted at edge k. Its bit i (in shift order) is on `dout` during cycle k+1+i, for i = 0..WIDTH-1.
- **Throughput:** one word every WIDTH cycles when `load_valid` is held high, with `dout_valid` continuously high.
- **`frame_done`** is high during cycle k+WIDTH+1.
- **Registered outputs:** all outputs are functions of registered state only, except `load_ready`, which is also state-only. No output has a combinational path from `load_valid` or `load_data`.

## Structure
- **Package `shift_reg_pkg`:** state enum `piso_state_t` {ST_IDLE, ST_SHIFT} and a function for the counter width (clog2 of WIDTH, minimum 1). A future SIPO refresh will share the package.
- **Sub-module `bit_counter`:** parameterised WIDTH, with a sync clear and an increment. It is the only natural split. Shift data path and FSM stay in `piso_shift_reg`.

## Test plan
All scenarios use WIDTH=4.
- **Single word, MSB first:** reset, then one load of 4'b1011 -> `dout` 1,0,1,1 on cycles k+1..k+4. `dout_valid` high for exactly 4 cycles, `last_bit` on cycle k+4, `frame_done` on cycle k+5, then `dout`=0 and `busy`=0.
- **LSB first:** MSB_FIRST=0, load 4'b1011 -> `dout` 1,1,0,1.
- **Back-to-back:** `load_valid` held high with 4'b1011 then 4'b0110 -> 8 gapless bits 1,0,1,1,0,1,1,0. `dout_valid` high for 8 cycles, `load_ready` high only in cycles k and k+4, `frame_done` pulses at k+5 and k+9.
- **Load while busy:** during bit 2 of 4'b1011, present 4'b0000 with `load_valid` -> it is ignored and the output stays 1,0,1,1. The word is accepted only in the `last_bit` cycle.
- **Reset mid-word:** `rst_n`=0 for one edge during bit 2 -> `dout`=0, `dout_valid`=0, `load_ready`=1 after that edge, and no `frame_done`. A subsequent load of 4'b0101 serialises to 0,1,0,1.
